// File: rtl/trigger_issue_stage_pkg.sv
// trigger_issue_stage_pkg: shared PE control types for the trigger issue path
package trigger_issue_stage_pkg;
    localparam int TIA_INSTRUCTION_INDEX_WIDTH = 4;
    localparam int TIA_MAX_NUM_INSTRUCTIONS = 1 << TIA_INSTRUCTION_INDEX_WIDTH;
    localparam int TIA_INSTRUCTION_WIDTH = 32;
    typedef logic [TIA_INSTRUCTION_WIDTH-1:0] instruction_t;
    typedef logic [TIA_INSTRUCTION_INDEX_WIDTH-1:0] index_t;
    typedef struct packed {
        logic         valid;
        logic         hazard;
        index_t       index;
        instruction_t instruction;
    } issue_slot_t;
endpackage

// File: rtl/trigger_issue_stage_skid_buffer.sv
// issue_skid_buffer: fetch slot that holds the imem read data in a skid register
// when the issue slot cannot take it in the cycle the memory returns it.
module issue_skid_buffer
    import trigger_issue_stage_pkg::*;
(
    input  logic         i_clock,
    input  logic         i_reset_n,
    input  logic         i_flush,
    input  logic         i_fire,
    input  index_t       i_fire_index,
    input  logic         i_fire_hazard,
    input  instruction_t i_imem_read_data,
    input  logic         i_sink_ready,
    output logic         o_advance,
    output issue_slot_t  o_slot
);
    logic         r_valid;
    logic         r_hazard;
    logic         r_skid_valid;
    index_t       r_index;
    instruction_t r_skid;

    assign o_advance = r_valid && i_sink_ready;
    assign o_slot = '{valid: r_valid, hazard: r_hazard, index: r_index,
                      instruction: r_skid_valid ? r_skid : i_imem_read_data};

    // Memory data is only guaranteed the cycle after the read, so park it if stuck.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_valid      <= 1'b0;
            r_hazard     <= 1'b0;
            r_index      <= '0;
            r_skid_valid <= 1'b0;
            r_skid       <= '0;
        end else if (i_flush) begin
            r_valid      <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (i_fire) begin
            r_valid      <= 1'b1;
            r_hazard     <= i_fire_hazard;
            r_index      <= i_fire_index;
            r_skid_valid <= 1'b0;
        end else if (o_advance) begin
            r_valid      <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (r_valid && !r_skid_valid) begin
            r_skid       <= i_imem_read_data;
            r_skid_valid <= 1'b1;
        end
    end
endmodule

// File: rtl/trigger_issue_stage.sv
// trigger_issue_stage: fetch/issue pipeline between trigger resolver and datapath.
// TIA_ISSUE_PERF_COUNTERS_EN adds issued_count/stall_count performance counters.
module trigger_issue_stage
    import trigger_issue_stage_pkg::*;
`ifdef TIA_ISSUE_PERF_COUNTERS_EN
#(
    parameter int PERF_COUNTER_WIDTH = 32
)
`endif
(
    input  logic                                clock,
    input  logic                                reset_n,
    input  logic                                enable,
    input  logic                                halted,
    input  logic                                flush,
    input  logic                                triggered_instruction_valid,
    input  index_t                              triggered_instruction_index,
    input  logic [TIA_MAX_NUM_INSTRUCTIONS-1:0] hazard_mask,
    input  logic                                downstream_hazard,
    output logic                                execute,
    output logic                                imem_read_enable,
    output index_t                              imem_read_index,
    input  instruction_t                        imem_read_data,
    output logic                                issue_valid,
    input  logic                                issue_ready,
    output index_t                              issue_index,
    output instruction_t                        issue_instruction,
    output logic                                idle
`ifdef TIA_ISSUE_PERF_COUNTERS_EN
    ,
    output logic [PERF_COUNTER_WIDTH-1:0]       issued_count,
    output logic [PERF_COUNTER_WIDTH-1:0]       stall_count
`endif
);
    logic        w_fire;
    logic        w_advance;
    logic        w_sink_ready;
    logic        w_hazard_in_flight;
    issue_slot_t w_f_slot;
    issue_slot_t r_i;

    assign w_sink_ready = !r_i.valid || issue_ready;
    assign w_hazard_in_flight = (w_f_slot.valid && w_f_slot.hazard) || (r_i.valid && r_i.hazard) ||
                                downstream_hazard;
    // reset_n gates execute so the resolver cannot fire while the pipeline is held in reset
    assign execute = reset_n && enable && !halted && !flush && !w_hazard_in_flight &&
                     (!w_f_slot.valid || w_advance);
    assign w_fire = triggered_instruction_valid && execute;
    assign imem_read_enable = w_fire;
    assign imem_read_index = w_fire ? triggered_instruction_index : '0;
    assign issue_valid = r_i.valid;
    assign issue_index = r_i.index;
    assign issue_instruction = r_i.instruction;
    assign idle = !w_f_slot.valid && !r_i.valid && !downstream_hazard;

    issue_skid_buffer u_fetch (
        .i_clock          (clock),
        .i_reset_n        (reset_n),
        .i_flush          (flush),
        .i_fire           (w_fire),
        .i_fire_index     (triggered_instruction_index),
        .i_fire_hazard    (hazard_mask[triggered_instruction_index]),
        .i_imem_read_data (imem_read_data),
        .i_sink_ready     (w_sink_ready),
        .o_advance        (w_advance),
        .o_slot           (w_f_slot)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            r_i <= '0;
        else if (flush)
            r_i.valid <= 1'b0;
        else if (w_advance)
            r_i <= w_f_slot;
        else if (r_i.valid && issue_ready)
            r_i.valid <= 1'b0;
    end

`ifdef TIA_ISSUE_PERF_COUNTERS_EN
    logic [PERF_COUNTER_WIDTH-1:0] r_issued_count;
    logic [PERF_COUNTER_WIDTH-1:0] r_stall_count;

    assign issued_count = r_issued_count;
    assign stall_count = r_stall_count;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_issued_count <= '0;
            r_stall_count  <= '0;
        end else if (flush) begin
            r_issued_count <= '0;
            r_stall_count  <= '0;
        end else begin
            r_issued_count <= r_issued_count + PERF_COUNTER_WIDTH'(r_i.valid && issue_ready);
            r_stall_count  <= r_stall_count + PERF_COUNTER_WIDTH'(r_i.valid && !issue_ready);
        end
    end
`endif
endmodule

// File: doc/trigger_issue_stage.md
# trigger_issue_stage

Issue stage directly downstream of the trigger resolution unit in each PE. It consumes the triggered instruction index, fetches the instruction word from the synchronous instruction memory, and presents it to the datapath through a valid/ready handshake. It also drives the resolver's `execute` input, throttling new triggers under backpressure or while an in-flight instruction may change predicates or channel state.

## Interface
- `PERF_COUNTER_WIDTH`, 32, width of the optional performance counters.
- `clock`  in  1  sole clock; all state on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  PE enable; low blocks new fetches only.
- `halted`  in  1  PE halted; low-going `execute`, drain continues.
- `flush`  in  1  synchronous; clears both pipeline slots.
- `triggered_instruction_valid`  in  1  resolver fired this cycle.
- `triggered_instruction_index`  in  TIA_INSTRUCTION_INDEX_WIDTH  fired index.
- `hazard_mask`  in  TIA_MAX_NUM_INSTRUCTIONS  bit i set = instruction i updates predicates or dequeues/enqueues channels.
- `downstream_hazard`  in  1  datapath still has a hazardous instruction past issue.
- `execute`  out  1  permission to the resolver to fire.
- `imem_read_enable`  out  1  instruction memory read strobe.
- `imem_read_index`  out  TIA_INSTRUCTION_INDEX_WIDTH  read address.
- `imem_read_data`  in  instruction_t  read data, valid one cycle after strobe.
- `issue_valid`  out  1  issue slot holds an instruction.
- `issue_ready`  in  1  datapath accepts.
- `issue_index`  out  TIA_INSTRUCTION_INDEX_WIDTH  index of issued instruction.
- `issue_instruction`  out  instruction_t  issued instruction word.
- `idle`  out  1  both slots empty and `downstream_hazard` low.

## Operation
- Two slots: F (fetch; index, valid, hazard bit, skid data register + skid valid) and I (issue; index, instruction, valid, hazard bit).
- `fire` = `triggered_instruction_valid && execute`. On fire: `imem_read_enable`=1, `imem_read_index` = `triggered_instruction_index` (combinational pass-through); F captures index and `hazard_mask[index]`.
- F→I advance when F valid and (I empty or `issue_ready`). Data source: skid register if skid valid, else `imem_read_data`.
- F valid but cannot advance in the cycle data returns: `imem_read_data` captured in skid register; skid used on advance, then cleared.
- I cleared on `issue_valid && issue_ready` unless refilled same cycle.
- `execute` = `enable && !halted && !flush && !hazard_in_flight && (F empty or F advancing)`; `hazard_in_flight` = (F valid && F hazard) or (I valid && I hazard) or `downstream_hazard`.
- `flush` clears F, I, skid; overrides a same-cycle fire (`execute` already low).
- `halted` never drops occupied slots; pipeline drains normally.
- Out-of-range index (≥ number of programmed instructions) is not checked; forwarded as is.

## Timing
- Reset: all valid bits 0; `execute`=0 during reset, `issue_valid`=0, `imem_read_enable`=0, `imem_read_index`=0, `issue_index`=0, `issue_instruction`='0, `idle`=1, counters 0.
- Latency: fire in cycle t → `issue_valid` in t+2 when unblocked.
- Throughput: one issue per cycle for back-to-back non-hazard instructions with `issue_ready` held high.
- Hazard instruction fired at t: `execute` low from t+1 until it leaves I and `downstream_hazard` is low.
- `issue_valid`/`issue_index`/`issue_instruction` stable while `issue_valid && !issue_ready`.
- Reset asserted mid-operation: all slots dropped immediately; no issue after deassertion without a new fire.

## Configuration
- `TIA_ISSUE_PERF_COUNTERS_EN` defined: adds outputs `issued_count` (increments per accepted issue) and `stall_count` (increments each cycle `issue_valid && !issue_ready`), both PERF_COUNTER_WIDTH, wrap to 0, cleared by reset and `flush`.
- Undefined: ports and counters absent; no other behaviour change.

## Structure
- Shared control package: `instruction_t`, TIA_INSTRUCTION_INDEX_WIDTH, TIA_MAX_NUM_INSTRUCTIONS, new `issue_slot_t` (valid, hazard, index, instruction).
- One sub-module: `issue_skid_buffer` (F slot plus skid register and advance logic).

## Test plan
- Non-hazard fires at indices 3, 4, 5 on consecutive cycles, `issue_ready`=1 → issues 3, 4, 5 on cycles t+2..t+4, `execute` stays 1.
- Fire index 2 with `hazard_mask[2]`=1 → `execute`=0 from t+1; returns to 1 the cycle after index 2 is accepted with `downstream_hazard`=0.
- `issue_ready`=0 for 4 cycles after fires of 1 and 6 → `issue_valid` held on 1, 6 retained via skid, issued in order after ready; no index lost or duplicated.
- `flush` while F and I occupied → `issue_valid`=0 next cycle, `idle`=1, later fire issues normally.
- Assert `reset_n`=0 with I full and `issue_ready`=0 → outputs at reset values immediately, `idle`=1.
- With macro: 10 accepted issues and 3 stall cycles → `issued_count`=10, `stall_count`=3; preload to all-ones then one issue → `issued_count`=0.
